// File: rtl/lvda_timing_pkg.sv
// lvda_timing_pkg: shared definitions for the LVDA timing chain.
//   state_e         - timing sequencer modes
//   DEF_*           - default phase/fan-out/slot geometry
//   cnt_width()     - counter width for a 0..n-1 range (never below 1)
//   bit_time_width()- width of the BIT_TIME index for a given word length
package lvda_timing_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN_ACTIVE,
    HALTING,
    STEP_ACTIVE
  } state_e;

  localparam int unsigned DEF_NUM_PHASES    = 4;
  localparam int unsigned DEF_FANOUT        = 8;
  localparam int unsigned DEF_SLOT_TICKS    = 4;
  localparam int unsigned DEF_GAP_TICKS     = 1;
  localparam int unsigned DEF_BITS_PER_WORD = 14;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned bit_time_width(input int unsigned bpw);
    return cnt_width(bpw);
  endfunction

endpackage

// File: rtl/phase_fanout.sv
// phase_fanout: registers a one-hot phase vector and replicates each phase
// FANOUT times.
//   clk_i   - clock
//   clr_i   - synchronous clear, active-high
//   phase_i - NUM_PHASES-wide phase enables
//   phase_o - registered copies; phase k copy j at bit k*FANOUT+j
module phase_fanout
  import lvda_timing_pkg::*;
#(
  parameter int unsigned NUM_PHASES = DEF_NUM_PHASES,
  parameter int unsigned FANOUT     = DEF_FANOUT
) (
  input  logic                         clk_i,
  input  logic                         clr_i,
  input  logic [NUM_PHASES-1:0]        phase_i,
  output logic [NUM_PHASES*FANOUT-1:0] phase_o
);

  logic [NUM_PHASES*FANOUT-1:0] phase_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      phase_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_PHASES; k++) begin
        phase_q[k*FANOUT +: FANOUT] <= {FANOUT{phase_i[k]}};
      end
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/timing_phase_gen.sv
// timing_phase_gen: generates non-overlapping phase clocks from SIM_CLK,
// fans them out, tracks bit time within a word, and supports run/halt/step.
//   SIM_CLK     - sole clock
//   SIM_RST     - synchronous reset, active-high
//   RUN         - free-run enable (level)
//   STEP        - single bit-time request (rising edge, honoured when idle)
//   PHASE_OUT   - phase k copy j at bit k*FANOUT+j
//   BIT_TIME    - current bit-time index within the word
//   WORD_STROBE - one-cycle pulse on the final cycle of a word
//   BUSY        - high while a bit time is in progress
module timing_phase_gen
  import lvda_timing_pkg::*;
#(
  parameter int unsigned NUM_PHASES    = DEF_NUM_PHASES,
  parameter int unsigned FANOUT        = DEF_FANOUT,
  parameter int unsigned SLOT_TICKS    = DEF_SLOT_TICKS,
  parameter int unsigned GAP_TICKS     = DEF_GAP_TICKS,
  parameter int unsigned BITS_PER_WORD = DEF_BITS_PER_WORD
) (
  input  logic                                     SIM_CLK,
  input  logic                                     SIM_RST,
  input  logic                                     RUN,
  input  logic                                     STEP,
  output logic [NUM_PHASES*FANOUT-1:0]             PHASE_OUT,
  output logic [bit_time_width(BITS_PER_WORD)-1:0] BIT_TIME,
  output logic                                     WORD_STROBE,
  output logic                                     BUSY
);

  if (NUM_PHASES < 1 || FANOUT < 1) begin : g_bad_geometry
    $error("timing_phase_gen: NUM_PHASES and FANOUT must be >= 1");
  end
  if (GAP_TICKS < 1 || GAP_TICKS >= SLOT_TICKS) begin : g_bad_gap
    $error("timing_phase_gen: need 1 <= GAP_TICKS < SLOT_TICKS");
  end
  if (BITS_PER_WORD < 2) begin : g_bad_word
    $error("timing_phase_gen: BITS_PER_WORD must be >= 2");
  end

  localparam int unsigned TICK_W = cnt_width(SLOT_TICKS);
  localparam int unsigned PH_W   = cnt_width(NUM_PHASES);
  localparam int unsigned BIT_W  = bit_time_width(BITS_PER_WORD);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SLOT_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_HIGH = TICK_W'(SLOT_TICKS - GAP_TICKS);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(NUM_PHASES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                step_prev_q;
  logic                busy_q, busy_d;
  logic                strobe_q, strobe_d;
  logic [NUM_PHASES-1:0] onehot_d;
  logic                step_rise;
  logic                bit_end;

  assign step_rise = STEP & ~step_prev_q;
  assign bit_end   = (tick_q == TICK_LAST) && (phase_q == PH_LAST);

  // Counters name the cycle currently on the outputs. While idle they rest at
  // the start of the next bit time, so a restart presents slot 0 immediately
  // and every output can be registered from the next-state values.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    phase_d = phase_q;
    bit_d   = bit_q;

    case (state_q)
      IDLE: begin
        if (RUN)            state_d = RUN_ACTIVE;
        else if (step_rise) state_d = STEP_ACTIVE;
      end
      RUN_ACTIVE: begin
        if (!RUN) state_d = bit_end ? IDLE : HALTING;
      end
      HALTING: begin
        if (RUN)          state_d = RUN_ACTIVE;
        else if (bit_end) state_d = IDLE;
      end
      STEP_ACTIVE: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end

    busy_d   = (state_d != IDLE);
    strobe_d = busy_d && (tick_d == TICK_LAST) && (phase_d == PH_LAST)
               && (bit_d == BIT_LAST);

    onehot_d = '0;
    for (int unsigned k = 0; k < NUM_PHASES; k++) begin
      onehot_d[k] = busy_d && (tick_d < TICK_HIGH) && (phase_d == PH_W'(k));
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      phase_q     <= '0;
      bit_q       <= '0;
      busy_q      <= 1'b0;
      strobe_q    <= 1'b0;
      step_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      busy_q      <= busy_d;
      strobe_q    <= strobe_d;
      step_prev_q <= STEP;
    end
  end

  phase_fanout #(
    .NUM_PHASES(NUM_PHASES),
    .FANOUT    (FANOUT)
  ) u_fanout (
    .clk_i  (SIM_CLK),
    .clr_i  (SIM_RST),
    .phase_i(onehot_d),
    .phase_o(PHASE_OUT)
  );

  assign BIT_TIME    = bit_q;
  assign WORD_STROBE = strobe_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_timing_phase_gen.sv
module tb_timing_phase_gen;

  logic clk = 1'b0;
  logic rst, run, step;

  logic [31:0] d_ph;
  logic [3:0]  d_bt;
  logic        d_ws, d_busy;

  logic [5:0]  s_ph;
  logic [2:0]  s_bt;
  logic        s_ws, s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timing_phase_gen u_dut (
    .SIM_CLK    (clk),
    .SIM_RST    (rst),
    .RUN        (run),
    .STEP       (step),
    .PHASE_OUT  (d_ph),
    .BIT_TIME   (d_bt),
    .WORD_STROBE(d_ws),
    .BUSY       (d_busy)
  );

  timing_phase_gen #(
    .NUM_PHASES   (2),
    .FANOUT       (3),
    .SLOT_TICKS   (3),
    .GAP_TICKS    (2),
    .BITS_PER_WORD(5)
  ) u_sweep (
    .SIM_CLK    (clk),
    .SIM_RST    (rst),
    .RUN        (run),
    .STEP       (step),
    .PHASE_OUT  (s_ph),
    .BIT_TIME   (s_bt),
    .WORD_STROBE(s_ws),
    .BUSY       (s_busy)
  );

  // Reference model: a bit time is a run of NP*SLOT cycles indexed by pos
  // (-1 when idle). Whether another bit time follows is decided only by RUN on
  // the last cycle, unless the bit time was started by a STEP edge.
  int p_np[2]   = '{4, 2};
  int p_fo[2]   = '{8, 3};
  int p_slot[2] = '{4, 3};
  int p_gap[2]  = '{1, 2};
  int p_bpw[2]  = '{14, 5};

  int m_pos[2];
  int m_bit[2];
  bit m_stepmode[2];
  bit m_prev[2];

  typedef struct {
    logic [31:0] ph;
    int          bt;
    bit          ws;
    bit          busy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t model_step(int i, bit r, bit ru, bit st);
    int   len;
    bit   rise;
    exp_t e;
    len = p_np[i] * p_slot[i];
    if (r) begin
      m_pos[i] = -1; m_bit[i] = 0; m_stepmode[i] = 0; m_prev[i] = 1;
    end else begin
      rise      = st && !m_prev[i];
      m_prev[i] = st;
      if (m_pos[i] < 0) begin
        if (ru) begin
          m_pos[i] = 0; m_stepmode[i] = 0;
        end else if (rise) begin
          m_pos[i] = 0; m_stepmode[i] = 1;
        end
      end else if (m_pos[i] == len - 1) begin
        m_bit[i] = (m_bit[i] + 1) % p_bpw[i];
        m_pos[i] = (!m_stepmode[i] && ru) ? 0 : -1;
      end else begin
        m_pos[i]++;
      end
    end
    e.ph   = '0;
    e.busy = (m_pos[i] >= 0);
    e.bt   = m_bit[i];
    e.ws   = e.busy && (m_pos[i] == len - 1) && (m_bit[i] == p_bpw[i] - 1);
    if (e.busy && (m_pos[i] % p_slot[i]) < (p_slot[i] - p_gap[i])) begin
      for (int j = 0; j < p_fo[i]; j++)
        e.ph[(m_pos[i] / p_slot[i]) * p_fo[i] + j] = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard producer: expectation for the outputs following each edge.
  always @(posedge clk) begin
    q0.push_back(model_step(0, rst, run, step));
    q1.push_back(model_step(1, rst, run, step));
  end

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] g0;
    logic [1:0] g1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("dflt_phase", d_ph, e.ph);
      chk("dflt_bit", {28'b0, d_bt}, e.bt);
      chk("dflt_strobe", {31'b0, d_ws}, {31'b0, e.ws});
      chk("dflt_busy", {31'b0, d_busy}, {31'b0, e.busy});
      for (int k = 0; k < 4; k++) g0[k] = |d_ph[k*8 +: 8];
      chk("dflt_overlap", {31'b0, $onehot0(g0)}, 32'd1);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("sweep_phase", {26'b0, s_ph}, e.ph);
      chk("sweep_bit", {29'b0, s_bt}, e.bt);
      chk("sweep_strobe", {31'b0, s_ws}, {31'b0, e.ws});
      chk("sweep_busy", {31'b0, s_busy}, {31'b0, e.busy});
      for (int k = 0; k < 2; k++) g1[k] = |s_ph[k*3 +: 3];
      chk("sweep_overlap", {31'b0, $onehot0(g1)}, 32'd1);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int busy_cnt;
    rst = 1'b1; run = 1'b0; step = 1'b0;
    repeat (3) nxt();

    // Free run from reset
    rst = 1'b0; run = 1'b1;
    for (int c = 1; c <= 226; c++) begin
      nxt();
      if (c == 1) chk("t1_busy_start", {31'b0, d_busy}, 32'd1);
      if (c <= 3) chk("t1_ph0_high", {24'b0, d_ph[7:0]}, 32'hFF);
      if (c == 4) chk("t1_ph0_gap", d_ph, 32'h0);
      if (c >= 5 && c <= 7) chk("t1_ph1_high", {24'b0, d_ph[15:8]}, 32'hFF);
      if (c == 16) chk("t1_bit_before", {28'b0, d_bt}, 32'd0);
      if (c == 17) chk("t1_bit_incr", {28'b0, d_bt}, 32'd1);
      if (c >= 223 && c <= 225) chk("t1_strobe", {31'b0, d_ws}, {31'b0, c == 224});
      if (c == 225) chk("t1_bit_wrap", {28'b0, d_bt}, 32'd0);
    end

    // RUN dropped mid bit 0
    rst = 1'b1; run = 1'b0;
    nxt();
    rst = 1'b0; run = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      nxt();
      if (c == 6) run = 1'b0;
      if (c == 13) chk("t2_ph3_high", {24'b0, d_ph[31:24]}, 32'hFF);
      if (c == 16) chk("t2_busy_last", {31'b0, d_busy}, 32'd1);
      if (c == 17) begin
        chk("t2_busy_off", {31'b0, d_busy}, 32'd0);
        chk("t2_phase_off", d_ph, 32'h0);
        chk("t2_bit_hold", {28'b0, d_bt}, 32'd1);
      end
    end

    // Step up to bit 13, then step across the word boundary
    for (int n = 0; n < 12; n++) begin
      step = 1'b1; nxt();
      step = 1'b0; repeat (18) nxt();
    end
    chk("t3_bit13", {28'b0, d_bt}, 32'd13);
    step = 1'b1;
    busy_cnt = 0;
    for (int c = 1; c <= 24; c++) begin
      nxt();
      if (c == 1) step = 1'b0;
      if (c == 5) step = 1'b1;
      if (c == 6) step = 1'b0;
      busy_cnt += int'(d_busy);
      if (c == 1) chk("t3_ph0_high", {24'b0, d_ph[7:0]}, 32'hFF);
      if (c == 15) chk("t3_strobe_early", {31'b0, d_ws}, 32'd0);
      if (c == 16) chk("t3_strobe", {31'b0, d_ws}, 32'd1);
      if (c == 17) begin
        chk("t3_busy_off", {31'b0, d_busy}, 32'd0);
        chk("t3_bit_wrap", {28'b0, d_bt}, 32'd0);
      end
    end
    chk("t3_one_bit_time", busy_cnt, 32'd16);

    // RUN and STEP rising together
    run = 1'b1; step = 1'b1;
    nxt();
    step = 1'b0;
    repeat (40) nxt();
    chk("t4_running", {31'b0, d_busy}, 32'd1);
    run = 1'b0;
    for (int k = 0; k < 20 && d_busy; k++) nxt();
    chk("t4_halt_timeout", {31'b0, d_busy}, 32'd0);
    busy_cnt = 0;
    repeat (20) begin
      nxt();
      busy_cnt += int'(d_busy);
    end
    chk("t4_no_extra_step", busy_cnt, 32'd0);

    // Reset while running, STEP held high through reset
    rst = 1'b1; nxt();
    rst = 1'b0; run = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      nxt();
      if (c == 8) step = 1'b1;
      if (c == 10) begin
        chk("t5_busy_pre", {31'b0, d_busy}, 32'd1);
        rst = 1'b1;
      end
    end
    nxt();
    chk("t5_phase_rst", d_ph, 32'h0);
    chk("t5_bit_rst", {28'b0, d_bt}, 32'd0);
    chk("t5_busy_rst", {31'b0, d_busy}, 32'd0);
    chk("t5_strobe_rst", {31'b0, d_ws}, 32'd0);
    rst = 1'b0; run = 1'b0;
    busy_cnt = 0;
    repeat (5) begin
      nxt();
      busy_cnt += int'(d_busy);
    end
    step = 1'b0;
    repeat (15) begin
      nxt();
      busy_cnt += int'(d_busy);
    end
    chk("t5_no_step", busy_cnt, 32'd0);

    // Randomized run/step/reset traffic
    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) run = ~run;
      step = ($urandom_range(0, 7) == 0);
    end
    rst = 1'b0; run = 1'b0; step = 1'b0;
    repeat (3) nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
